// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//
// Turns the line-following controller's per-motor direction pairs and 4-bit
// duty commands into the four H-bridge input pins of the two drive motors.
// A shared prescaler/step counter defines the PWM period. Each motor has a
// direction FSM that inserts DEAD_PERIODS full periods of "both low" on a
// forward/reverse reversal so the bridge never shoots through.
//
// Commands (direction and duty) are sampled only at a PWM period boundary,
// so the waveform of a period is never disturbed mid-way.
//
// Direction code {a,b}: 10 = forward, 01 = reverse, 00 = coast, 11 = brake.
//
// Optional build macro:
//   SOFT_START_EN - applied duty ramps one step per period toward the
//                   (saturated) command instead of jumping to it.
//
// Ports:
//   clk_3125KHz     in   system clock
//   rst             in   asynchronous, active-high reset
//   enable          in   drive enable; low forces everything idle
//   m1_a, m1_b      in   motor 1 direction pair
//   m2_a, m2_b      in   motor 2 direction pair
//   dc1, dc2        in   4-bit duty commands (saturated to PWM_STEPS)
//   motor1_in1/2    out  H-bridge inputs, motor 1 (registered)
//   motor2_in1/2    out  H-bridge inputs, motor 2 (registered)
//   period_start    out  one-cycle pulse after each period boundary
//   dead_active     out  high while either motor is in dead time
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
    parameter int PRESCALE     = 31,
    parameter int PWM_STEPS    = 10,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clk_3125KHz,
    input  logic       rst,
    input  logic       enable,
    input  logic       m1_a,
    input  logic       m1_b,
    input  logic       m2_a,
    input  logic       m2_b,
    input  logic [3:0] dc1,
    input  logic [3:0] dc2,
    output logic       motor1_in1,
    output logic       motor1_in2,
    output logic       motor2_in1,
    output logic       motor2_in2,
    output logic       period_start,
    output logic       dead_active
);

    localparam int PW = (PRESCALE > 1)     ? $clog2(PRESCALE)       : 1;
    localparam int SW = (PWM_STEPS > 1)    ? $clog2(PWM_STEPS)      : 1;
    localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS+1) : 1;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_BRAKE = 3'd3,
        ST_DEAD  = 3'd4
    } state_t;

    // ---------------------------------------------------------------------
    // Timebase: prescaler -> step counter -> period boundary
    // ---------------------------------------------------------------------
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_step;
    logic          r_period_start;
    logic          w_tick;
    logic          w_boundary;

    assign w_tick     = (r_presc == PW'(PRESCALE - 1));
    assign w_boundary = w_tick && (r_step == SW'(PWM_STEPS - 1));

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            r_presc        <= '0;
            r_step         <= '0;
            r_period_start <= 1'b0;
        end else if (!enable) begin
            r_presc        <= '0;
            r_step         <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;
            if (w_tick) begin
                r_presc <= '0;
                r_step  <= w_boundary ? '0 : r_step + SW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-motor command inputs (index 0 = motor 1, index 1 = motor 2)
    // ---------------------------------------------------------------------
    logic [1:0] w_cmd [2];
    logic [3:0] w_dc  [2];
    logic [3:0] w_sat [2];

    assign w_cmd[0] = {m1_a, m1_b};
    assign w_cmd[1] = {m2_a, m2_b};
    assign w_dc[0]  = dc1;
    assign w_dc[1]  = dc2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_sat[i] = (32'(w_dc[i]) > PWM_STEPS) ? 4'(PWM_STEPS) : w_dc[i];
        end
    end

    // Commanded state as if coming from STOP (no reversal involved).
    function automatic state_t f_cmd_state(input logic [1:0] cmd);
        case (cmd)
            2'b10:   f_cmd_state = ST_FWD;
            2'b01:   f_cmd_state = ST_REV;
            2'b11:   f_cmd_state = ST_BRAKE;
            default: f_cmd_state = ST_STOP;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Direction FSMs: state register / next-state logic / output logic
    // ---------------------------------------------------------------------
    state_t        r_state    [2];
    state_t        w_state_nxt[2];
    logic [DW-1:0] r_dead_cnt [2];
    logic [DW-1:0] w_dead_nxt [2];
    logic [3:0]    r_duty     [2];
    logic [3:0]    w_duty_nxt [2];

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]    <= ST_STOP;
                r_dead_cnt[i] <= '0;
                r_duty[i]     <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]    <= ST_STOP;
                r_dead_cnt[i] <= '0;
                r_duty[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_dead_cnt[i] <= w_dead_nxt[i];
                r_duty[i]     <= w_duty_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            w_dead_nxt[i]  = r_dead_cnt[i];
            w_duty_nxt[i]  = r_duty[i];
            if (w_boundary) begin
                if (r_state[i] == ST_DEAD) begin
                    // Leaving dead time takes the command sampled now,
                    // evaluated from STOP so no second dead time follows.
                    if (r_dead_cnt[i] <= DW'(1)) begin
                        w_dead_nxt[i]  = '0;
                        w_state_nxt[i] = f_cmd_state(w_cmd[i]);
                    end else begin
                        w_dead_nxt[i]  = r_dead_cnt[i] - DW'(1);
                    end
                end else begin
                    w_state_nxt[i] = f_cmd_state(w_cmd[i]);
                    if ((DEAD_PERIODS > 0) &&
                        (((r_state[i] == ST_FWD) && (w_cmd[i] == 2'b01)) ||
                         ((r_state[i] == ST_REV) && (w_cmd[i] == 2'b10)))) begin
                        w_state_nxt[i] = ST_DEAD;
                        w_dead_nxt[i]  = DW'(DEAD_PERIODS);
                    end
                end
`ifdef SOFT_START_EN
                // Ramp one step per period; idle states restart the ramp.
                case (w_state_nxt[i])
                    ST_STOP, ST_DEAD: w_duty_nxt[i] = '0;
                    ST_FWD, ST_REV: begin
                        if (r_duty[i] < w_sat[i])
                            w_duty_nxt[i] = r_duty[i] + 4'd1;
                        else if (r_duty[i] > w_sat[i])
                            w_duty_nxt[i] = r_duty[i] - 4'd1;
                    end
                    default: w_duty_nxt[i] = r_duty[i];
                endcase
`else
                w_duty_nxt[i] = w_sat[i];
`endif
            end
        end
    end

    // Output logic: computed from the current step/state/duty and
    // registered, so pins lag the step counter by exactly one cycle.
    logic [1:0] w_in1;
    logic [1:0] w_in2;
    logic       w_dead_any;
    logic [1:0] r_in1;
    logic [1:0] r_in2;
    logic       r_dead_active;

    always_comb begin
        w_in1 = '0;
        w_in2 = '0;
        for (int i = 0; i < 2; i++) begin
            case (r_state[i])
                ST_FWD:   w_in1[i] = (32'(r_step) < 32'(r_duty[i]));
                ST_REV:   w_in2[i] = (32'(r_step) < 32'(r_duty[i]));
                ST_BRAKE: begin
                    w_in1[i] = 1'b1;
                    w_in2[i] = 1'b1;
                end
                default: begin
                    w_in1[i] = 1'b0;
                    w_in2[i] = 1'b0;
                end
            endcase
        end
        w_dead_any = (r_state[0] == ST_DEAD) || (r_state[1] == ST_DEAD);
    end

    always_ff @(posedge clk_3125KHz or posedge rst) begin
        if (rst) begin
            r_in1         <= '0;
            r_in2         <= '0;
            r_dead_active <= 1'b0;
        end else if (!enable) begin
            r_in1         <= '0;
            r_in2         <= '0;
            r_dead_active <= 1'b0;
        end else begin
            r_in1         <= w_in1;
            r_in2         <= w_in2;
            r_dead_active <= w_dead_any;
        end
    end

    assign motor1_in1   = r_in1[0];
    assign motor1_in2   = r_in2[0];
    assign motor2_in1   = r_in1[1];
    assign motor2_in2   = r_in2[1];
    assign period_start = r_period_start;
    assign dead_active  = r_dead_active;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
//
// Bench for motor_pwm_driver with PRESCALE=2, PWM_STEPS=10, DEAD_PERIODS=2
// (20-clock PWM period). The stimulus pushes the expected per-period pin
// statistics into exp_q; a monitor accumulates the pins between
// period_start pulses and pops/compares one entry per closed period.
// Window record: {length, m1_in1 high, m1_in2 high, m2_in1 high, m2_in2 high,
//                 dead_active high, bridge violations}, 8 bits each. A
// violation is a cycle with in1 = in2 = 1 or a direct FWD<->REV pin change.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

    localparam int W = 56;

    logic       clk_3125KHz;
    logic       rst;
    logic       enable;
    logic       m1_a, m1_b, m2_a, m2_b;
    logic [3:0] dc1, dc2;
    logic       motor1_in1, motor1_in2, motor2_in1, motor2_in2;
    logic       period_start, dead_active;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];

    motor_pwm_driver #(
        .PRESCALE    (2),
        .PWM_STEPS   (10),
        .DEAD_PERIODS(2)
    ) dut (
        .clk_3125KHz (clk_3125KHz),
        .rst         (rst),
        .enable      (enable),
        .m1_a        (m1_a),
        .m1_b        (m1_b),
        .m2_a        (m2_a),
        .m2_b        (m2_b),
        .dc1         (dc1),
        .dc2         (dc2),
        .motor1_in1  (motor1_in1),
        .motor1_in2  (motor1_in2),
        .motor2_in1  (motor2_in1),
        .motor2_in2  (motor2_in2),
        .period_start(period_start),
        .dead_active (dead_active)
    );

    // Clock
    initial clk_3125KHz = 1'b0;
    always #5 clk_3125KHz = ~clk_3125KHz;

    function automatic logic [W-1:0] mk(input int len, input int a1, input int a2,
                                        input int b1, input int b2, input int dd,
                                        input int vv);
        mk = {8'(len), 8'(a1), 8'(a2), 8'(b1), 8'(b2), 8'(dd), 8'(vv)};
    endfunction

    // Monitor / scoreboard
    int         c_len, c11, c12, c21, c22, c_dead, c_viol, win_idx;
    bit         started;
    logic [1:0] prev1, prev2;
    logic [W-1:0] got_w, exp_w;

    initial begin
        c_len = 0; c11 = 0; c12 = 0; c21 = 0; c22 = 0; c_dead = 0; c_viol = 0;
        win_idx = 0; started = 0; prev1 = 2'b00; prev2 = 2'b00;
    end

    always @(negedge clk_3125KHz) begin
        c_len  += 1;
        c11    += int'(motor1_in1);
        c12    += int'(motor1_in2);
        c21    += int'(motor2_in1);
        c22    += int'(motor2_in2);
        c_dead += int'(dead_active);
        if ((motor1_in1 && motor1_in2) || (motor2_in1 && motor2_in2) ||
            (prev1 == 2'b10 && {motor1_in1, motor1_in2} == 2'b01) ||
            (prev1 == 2'b01 && {motor1_in1, motor1_in2} == 2'b10) ||
            (prev2 == 2'b10 && {motor2_in1, motor2_in2} == 2'b01) ||
            (prev2 == 2'b01 && {motor2_in1, motor2_in2} == 2'b10))
            c_viol += 1;
        prev1 = {motor1_in1, motor1_in2};
        prev2 = {motor2_in1, motor2_in2};
        if (period_start === 1'b1) begin
            if (started && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                got_w = mk(c_len, c11, c12, c21, c22, c_dead, c_viol);
                vectors += 1;
                win_idx += 1;
                if (got_w !== exp_w) begin
                    miscompares += 1;
                    $display("FAIL window%0d: got len/m1in1/m1in2/m2in1/m2in2/dead/viol=%0d/%0d/%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                             win_idx, got_w[55:48], got_w[47:40], got_w[39:32], got_w[31:24],
                             got_w[23:16], got_w[15:8], got_w[7:0], exp_w[55:48], exp_w[47:40],
                             exp_w[39:32], exp_w[31:24], exp_w[23:16], exp_w[15:8], exp_w[7:0]);
                end
            end
            started = 1;
            c_len = 0; c11 = 0; c12 = 0; c21 = 0; c22 = 0; c_dead = 0; c_viol = 0;
        end
    end

    // Driver tasks
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors += 1;
        if (got !== req) begin
            miscompares += 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_3125KHz);
        #1;
    endtask

    // Waits for the next period_start; returns the number of negedges taken.
    task automatic wait_ps(output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_3125KHz);
            n = k;
            if (period_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors += 1;
            miscompares += 1;
            $display("FAIL period_start_timeout: got none in %0d clocks required one", n);
        end
        #1;
    endtask

    task automatic win(input logic [W-1:0] e);
        int n;
        exp_q.push_back(e);
        wait_ps(n);
    endtask

    function automatic logic [31:0] outs();
        outs = {26'd0, motor1_in1, motor1_in2, motor2_in1, motor2_in2,
                period_start, dead_active};
    endfunction

    // Stimulus
    initial begin
        int n;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        enable = 1'b0;
        {m1_a, m1_b} = 2'b10; dc1 = 4'd7;
        {m2_a, m2_b} = 2'b01; dc2 = 4'd15;

        @(negedge clk_3125KHz);
        check("reset_outputs", outs(), 32'd0);
        wait_clks(2);
        rst = 1'b0;
        enable = 1'b1;
        wait_ps(n);
        check("first_boundary_latency", 32'(n), 32'd20);

        dc1 = 4'd5; dc2 = 4'd0;
        win(mk(20, 14, 0, 0, 20, 0, 0));        // m1 FWD 7, m2 REV 15 (sat)
        {m1_a, m1_b} = 2'b01; {m2_a, m2_b} = 2'b00;
        win(mk(20, 10, 0, 0, 0, 0, 0));         // m1 FWD 5, m2 REV 0
        win(mk(20, 0, 0, 0, 0, 20, 0));         // m1 dead period 1
        win(mk(20, 0, 0, 0, 0, 20, 0));         // m1 dead period 2
        {m2_a, m2_b} = 2'b10; dc2 = 4'd3;
        win(mk(20, 0, 10, 0, 0, 0, 0));         // m1 REV 5

        // Mid-period duty change on motor 2 at step 4
        exp_q.push_back(mk(20, 0, 10, 6, 0, 0, 0));
        wait_clks(9);
        dc2 = 4'd8;
        wait_ps(n);

        {m1_a, m1_b} = 2'b10; {m2_a, m2_b} = 2'b01;
        win(mk(20, 0, 10, 16, 0, 0, 0));        // new duty 8 applies now
        win(mk(20, 0, 0, 0, 0, 20, 0));         // both motors dead
        win(mk(20, 0, 0, 0, 0, 20, 0));
        {m1_a, m1_b} = 2'b11;
        win(mk(20, 10, 0, 0, 16, 0, 0));        // m1 FWD 5, m2 REV 8
        {m1_a, m1_b} = 2'b00;
        win(mk(20, 20, 20, 0, 16, 0, 20));      // m1 brake
        {m1_a, m1_b} = 2'b10; dc1 = 4'd10; {m2_a, m2_b} = 2'b10;
        win(mk(20, 0, 0, 0, 16, 0, 0));         // m1 coast

        // Reset in the middle of motor 2 dead time, motor 1 driving high
        wait_clks(7);
        check("pre_reset_dead_active", 32'(dead_active), 32'd1);
        check("pre_reset_m1_in1", 32'(motor1_in1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 32'd0);
        wait_clks(2);
        rst = 1'b0;
        wait_clks(10);
        check("stop_after_reset", outs(), 32'd0);
        wait_ps(n);
        check("boundary_after_reset", 32'(n), 32'd10);
        win(mk(20, 20, 0, 16, 0, 0, 0));        // reversal discarded: m2 FWD direct

        // Enable drop and restart
        wait_clks(5);
        check("pre_disable_m1_in1", 32'(motor1_in1), 32'd1);
        enable = 1'b0;
        @(negedge clk_3125KHz);
        check("disable_outputs_next_clk", outs(), 32'd0);
        wait_clks(6);
        dc1 = 4'd7;
        enable = 1'b1;
        wait_ps(n);
        check("boundary_after_reenable", 32'(n), 32'd20);
        win(mk(20, 14, 0, 16, 0, 0, 0));

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
